// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Completed-access counter width and its saturation value.
    localparam int             ACC_W   = 16;
    localparam logic [ACC_W-1:0] ACC_MAX = 16'hFFFF;

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between the core's load/store path and the responder.
interface dmem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_adr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_adr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_adr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Byte storage with asynchronous clear, one write port and one registered read port.
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              rd_zero_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage: cleared on reset, written only when the caller has range-checked the index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register: loads the word, or zero for stores/errors; otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= rd_zero_i ? '0 : mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
//
//   state | meaning
//   IDLE  | ready for a request; req_ready=1
//   WAIT  | request captured, latency down-counter running
//   RESP  | response presented until rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_if.slave            bus,
    output logic [ACC_W-1:0] acc_count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [ADDR_W-1:0]  adr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               err_q;
    logic [ACC_W-1:0]   acc_count_q;

    logic               accept;
    logic               access;
    logic               acc_we;
    logic [ADDR_W-1:0]  acc_adr;
    logic [DATA_W-1:0]  acc_wdata;
    logic               in_range;

    assign accept = (state_q == IDLE) && bus.req_valid;
    assign access = (state_d == RESP) && (state_q != RESP);

    // With LATENCY=1 the access edge is the accept edge, so the live request is used directly.
    assign acc_we    = (state_q == IDLE) ? bus.req_we    : we_q;
    assign acc_adr   = (state_q == IDLE) ? bus.req_adr   : adr_q;
    assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign in_range  = {1'b0, acc_adr} < (ADDR_W+1)'(DEPTH);

    // State and latency counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: counter terminal count of 1 marks the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) state_d = RESP;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture so later input changes cannot disturb the transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            adr_q   <= bus.req_adr;
            wdata_q <= bus.req_wdata;
        end
    end

    // Error flag is decided on the access edge and held until the next access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       err_q <= 1'b0;
        else if (access) err_q <= ~in_range;
    end

    // Saturating count of completed response handshakes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_count_q <= '0;
        end else if ((state_q == RESP) && bus.rsp_ready && (acc_count_q != ACC_MAX)) begin
            acc_count_q <= acc_count_q + ACC_W'(1);
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk       (clk),
        .rst       (reset),
        .wr_en_i   (access & acc_we & in_range),
        .rd_en_i   (access),
        .rd_zero_i (acc_we | ~in_range),
        .idx_i     (acc_adr[IDX_W-1:0]),
        .wdata_i   (acc_wdata),
        .rdata_o   (bus.rsp_rdata)
    );

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = err_q;
    assign acc_count     = acc_count_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default, DEPTH=16 and LATENCY=1 instances.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       rv [3];
    logic       we [3];
    logic       rr [3];
    logic [7:0] adr [3];
    logic [7:0] wd [3];
    logic       rq [3];
    logic       vs [3];
    logic       er [3];
    logic [7:0] rd [3];
    logic [15:0] cnt [3];

    int n_cmp = 0;
    int n_bad = 0;

    dmem_if #(.ADDR_W(8), .DATA_W(8)) b0 ();
    dmem_if #(.ADDR_W(8), .DATA_W(8)) b1 ();
    dmem_if #(.ADDR_W(8), .DATA_W(8)) b2 ();

    assign b0.req_valid = rv[0]; assign b0.req_we = we[0]; assign b0.req_adr = adr[0];
    assign b0.req_wdata = wd[0]; assign b0.rsp_ready = rr[0];
    assign rq[0] = b0.req_ready; assign vs[0] = b0.rsp_valid;
    assign rd[0] = b0.rsp_rdata; assign er[0] = b0.rsp_err;

    assign b1.req_valid = rv[1]; assign b1.req_we = we[1]; assign b1.req_adr = adr[1];
    assign b1.req_wdata = wd[1]; assign b1.rsp_ready = rr[1];
    assign rq[1] = b1.req_ready; assign vs[1] = b1.rsp_valid;
    assign rd[1] = b1.rsp_rdata; assign er[1] = b1.rsp_err;

    assign b2.req_valid = rv[2]; assign b2.req_we = we[2]; assign b2.req_adr = adr[2];
    assign b2.req_wdata = wd[2]; assign b2.rsp_ready = rr[2];
    assign rq[2] = b2.req_ready; assign vs[2] = b2.rsp_valid;
    assign rd[2] = b2.rsp_rdata; assign er[2] = b2.rsp_err;

    dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .bus(b0), .acc_count(cnt[0]));
    dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .LATENCY(2)) dut1 (
        .clk(clk), .reset(reset), .bus(b1), .acc_count(cnt[1]));
    dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(1)) dut2 (
        .clk(clk), .reset(reset), .bus(b2), .acc_count(cnt[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full access with rsp_ready high; request inputs are scrambled right after accept.
    task automatic do_acc(input int d, input logic w, input logic [7:0] a, input logic [7:0] wdat,
                          input int lat, output logic [7:0] rdo, output logic erro);
        int n;
        chk("acc_rdy", 32'(rq[d]), 1);
        rv[d] = 1'b1; we[d] = w; adr[d] = a; wd[d] = wdat; rr[d] = 1'b1;
        @(posedge clk); #1;
        rv[d] = 1'b0; we[d] = ~w; adr[d] = ~a; wd[d] = ~wdat;
        n = 1;
        while (vs[d] !== 1'b1 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk("acc_lat", 32'(n), 32'(lat));
        rdo  = rd[d];
        erro = er[d];
        @(posedge clk); #1;
        chk("acc_done", 32'(vs[d]), 0);
    endtask

    logic [7:0] r;
    logic       e;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; we[i] = 1'b0; rr[i] = 1'b1; adr[i] = '0; wd[i] = '0;
        end
        reset = 1'b1;
        #1;
        chk("rst_rdy",  32'(rq[0]),  1);
        chk("rst_vld",  32'(vs[0]),  0);
        chk("rst_data", 32'(rd[0]),  0);
        chk("rst_err",  32'(er[0]),  0);
        chk("rst_cnt",  32'(cnt[0]), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // default instance: load of cleared storage, then store/load
        do_acc(0, 1'b0, 8'h10, 8'h00, 2, r, e);
        chk("ld10_data", 32'(r), 0);
        chk("ld10_err",  32'(e), 0);
        chk("ld10_cnt",  32'(cnt[0]), 1);
        do_acc(0, 1'b1, 8'h20, 8'h5A, 2, r, e);
        chk("st20_data", 32'(r), 0);
        chk("st20_err",  32'(e), 0);
        do_acc(0, 1'b0, 8'h20, 8'h00, 2, r, e);
        chk("ld20_data", 32'(r), 'h5A);
        chk("ld20_cnt",  32'(cnt[0]), 3);

        // DEPTH=16 instance: in-range store, out-of-range store/load, boundary address
        do_acc(1, 1'b1, 8'h0F, 8'h77, 2, r, e);
        chk("d16_st0f_err", 32'(e), 0);
        do_acc(1, 1'b1, 8'h30, 8'hFF, 2, r, e);
        chk("d16_st30_data", 32'(r), 0);
        chk("d16_st30_err",  32'(e), 1);
        chk("d16_err_held",  32'(er[1]), 1);
        do_acc(1, 1'b0, 8'h30, 8'h00, 2, r, e);
        chk("d16_ld30_data", 32'(r), 0);
        chk("d16_ld30_err",  32'(e), 1);
        do_acc(1, 1'b0, 8'h10, 8'h00, 2, r, e);
        chk("d16_ld10_err",  32'(e), 1);
        do_acc(1, 1'b0, 8'h0F, 8'h00, 2, r, e);
        chk("d16_ld0f_data", 32'(r), 'h77);
        chk("d16_ld0f_err",  32'(e), 0);
        chk("d16_cnt",       32'(cnt[1]), 5);

        // rsp_ready low in RESP for 5 cycles with a competing store presented
        rv[0] = 1'b1; we[0] = 1'b0; adr[0] = 8'h20; rr[0] = 1'b0;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        @(posedge clk); #1;
        chk("hold_enter", 32'(vs[0]), 1);
        for (int i = 0; i < 5; i++) begin
            rv[0] = 1'b1; we[0] = 1'b1; adr[0] = 8'h20; wd[0] = 8'h11;
            @(posedge clk); #1;
            chk("hold_vld",  32'(vs[0]), 1);
            chk("hold_data", 32'(rd[0]), 'h5A);
            chk("hold_rdy",  32'(rq[0]), 0);
        end
        rv[0] = 1'b0; rr[0] = 1'b1;
        @(posedge clk); #1;
        chk("hold_done", 32'(vs[0]), 0);
        chk("hold_keep", 32'(rd[0]), 'h5A);
        chk("hold_cnt",  32'(cnt[0]), 4);
        do_acc(0, 1'b0, 8'h20, 8'h00, 2, r, e);
        chk("hold_noeff", 32'(r), 'h5A);

        // reset while a store sits in WAIT
        rv[0] = 1'b1; we[0] = 1'b1; adr[0] = 8'h04; wd[0] = 8'hAA;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        chk("wait_busy", 32'(rq[0]), 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_rdy", 32'(rq[0]),  1);
        chk("mid_rst_cnt", 32'(cnt[0]), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_novld", 32'(vs[0]), 0);
        end
        do_acc(0, 1'b0, 8'h04, 8'h00, 2, r, e);
        chk("mid_rst_ld04", 32'(r), 0);
        chk("mid_rst_cnt1", 32'(cnt[0]), 1);

        // LATENCY=1 instance: store/load, then saturation of the access counter
        do_acc(2, 1'b1, 8'h05, 8'h3C, 1, r, e);
        chk("l1_st_err", 32'(e), 0);
        do_acc(2, 1'b0, 8'h05, 8'h00, 1, r, e);
        chk("l1_ld_data", 32'(r), 'h3C);
        chk("l1_cnt",     32'(cnt[2]), 2);
        force dut2.acc_count_q = 16'hFFFD;
        do_acc(2, 1'b0, 8'h05, 8'h00, 1, r, e);
        release dut2.acc_count_q;
        for (int i = 0; i < 4; i++) do_acc(2, 1'b0, 8'h05, 8'h00, 1, r, e);
        chk("l1_sat", 32'(cnt[2]), 'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
